character_motion_controller: RTL and testbench
==============================================

# character_motion_controller

Per-tick movement state machine for the player character. It turns debounced buttons and terrain contact flags into the 3-bit character state and the signed X/Y velocities. It sits directly upstream of the display state controller, which consumes `char_state` and `vel_y`, and of the position integrator, which consumes `vel_x` and `vel_y`. All state changes happen only on `character_clk` ticks.

## Interface
- SIGNED_PHY_WIDTH, 17, width of the signed velocity outputs
- MAX_VEL_Y, 10, launch/fall speed cap (positive magnitude)
- MAX_VEL_X, 4, horizontal speed magnitude for walking and jumping
- GRAVITY, 1, vel_y decrement per airborne tick
- LAND_TICKS, 2, ticks spent in FALL_TO_GROUND
- CHARGE_WIDTH, $clog2(MAX_VEL_Y+1), width of charge counter
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- character_clk  in  1  one-sys_clk-wide physics tick strobe
- btn_left, btn_right, btn_jump  in  1 each  debounced levels
- freeze  in  1  pause request (level transition / menu)
- on_ground  in  1  character feet touch solid tile
- hit_wall  in  1  horizontal contact this tick
- hit_ceiling  in  1  head contact this tick
- char_state  out  3  IDLE=0 LEFT=1 RIGHT=2 CHARGE=3 JUMP=4 COLLISION=5 FALL_TO_GROUND=6 HOLD=7
- vel_x  out  SIGNED_PHY_WIDTH  signed, +right
- vel_y  out  SIGNED_PHY_WIDTH  signed, +up
- charge  out  CHARGE_WIDTH  current jump charge
- face_left  out  1  sprite facing

## Operation
- Reset: char_state=IDLE, vel_x=0, vel_y=0, charge=0, face_left=0, saved state=IDLE.
- Registers update only on sys_clk edges where character_clk=1. Inputs on other cycles are ignored.
- Priority per tick: freeze, then state logic.
- HOLD: when freeze=1, save the current state and enter HOLD. All other outputs stay frozen. On the first tick with freeze=0, restore the saved state and do no physics update that tick. freeze while already in HOLD keeps HOLD.
- IDLE/LEFT/RIGHT (grounded), priority order:
  - !on_ground: enter JUMP with vel_y=0; vel_x keeps its walk value.
  - btn_jump: enter CHARGE with charge=1 and vel_x=0.
  - btn_left && !btn_right: enter LEFT with vel_x=-MAX_VEL_X and face_left=1.
  - btn_right && !btn_left: enter RIGHT with vel_x=+MAX_VEL_X and face_left=0.
  - Otherwise: enter IDLE with vel_x=0.
  - vel_y=0 throughout.
- CHARGE:
  - !on_ground: enter JUMP with vel_y=0 and charge=0.
  - btn_jump held: charge saturating +1, capped at MAX_VEL_Y.
  - btn_jump released: enter JUMP with vel_y=charge and charge=0. vel_x is ±MAX_VEL_X if exactly one direction button is held, else 0; face_left updates to match.
- JUMP (airborne):
  - vel_y ← max(vel_y−GRAVITY, −MAX_VEL_Y).
  - hit_ceiling && vel_y>0: vel_y ← 0 instead of the decrement.
  - hit_wall: enter COLLISION, vel_x ← −vel_x, face_left toggles. vel_y rule applies the same tick.
  - on_ground && vel_y≤0: enter FALL_TO_GROUND with vel_x=0. vel_y keeps the impact value, with no decrement that tick. Landing beats hit_wall.
- COLLISION: lasts one tick. Apply the same gravity/ceiling rule, then return to JUMP. The landing rule applies in COLLISION too.
- FALL_TO_GROUND:
  - Stays LAND_TICKS ticks; a land counter is cleared on entry.
  - First tick after entry: vel_y ← 0.
  - After LAND_TICKS ticks: enter IDLE.
  - Buttons are ignored; !on_ground re-enters JUMP with vel_y=0.
- Arithmetic: signed saturating, SIGNED_PHY_WIDTH bits. vel_y never leaves [−MAX_VEL_Y, MAX_VEL_Y].

## Timing
- Outputs are registered and change one sys_clk cycle after the tick edge. There is no combinational input-to-output path.
- Decision latency: one tick from input to state change.
- Reset is synchronous and overrides character_clk and freeze in the same cycle.
- Reset mid-jump: the next cycle shows IDLE with zero velocities.
- Outputs are stable between ticks, so downstream may sample on any cycle.

## Test plan
- Reset, then 3 ticks with no buttons and on_ground=1 → IDLE, vel_x=0, vel_y=0, charge=0.
- btn_jump held 15 ticks (MAX_VEL_Y=10) with btn_right=1, then released → charge peaks at 10; next tick JUMP, vel_y=10, vel_x=+4, face_left=0.
- Free fall from vel_y=0 with on_ground=0 for 12 ticks → vel_y=−1…−10, then holds −10. on_ground=1 → FALL_TO_GROUND with vel_y=−10, next tick vel_y=0, then IDLE.
- JUMP with vel_x=+4, vel_y=5, hit_wall=1 for one tick → COLLISION, vel_x=−4, vel_y=4, face_left=1; next tick JUMP, vel_y=3.
- JUMP vel_y=6 with hit_ceiling=1 and hit_wall=1 the same tick → COLLISION, vel_y=0, vel_x negated.
- freeze=1 during CHARGE (charge=4) for 5 ticks → HOLD, charge stays 4; freeze=0 → CHARGE restored, charge=4. Assert sys_rst during JUMP → IDLE and all zeros the next cycle.

Source files
------------

// File: rtl/character_motion_controller_if.sv
// Signal bundle between the player input/terrain logic and the motion controller.
// The master drives buttons, tick and contact flags; the slave returns motion state.
interface character_motion_controller_if #(
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int CHARGE_WIDTH     = 4
);
    logic                               character_clk;
    logic                               btn_left;
    logic                               btn_right;
    logic                               btn_jump;
    logic                               freeze;
    logic                               on_ground;
    logic                               hit_wall;
    logic                               hit_ceiling;
    logic [2:0]                         char_state;
    logic signed [SIGNED_PHY_WIDTH-1:0] vel_x;
    logic signed [SIGNED_PHY_WIDTH-1:0] vel_y;
    logic [CHARGE_WIDTH-1:0]            charge;
    logic                               face_left;

    modport master (
        output character_clk, btn_left, btn_right, btn_jump,
        output freeze, on_ground, hit_wall, hit_ceiling,
        input  char_state, vel_x, vel_y, charge, face_left
    );

    modport slave (
        input  character_clk, btn_left, btn_right, btn_jump,
        input  freeze, on_ground, hit_wall, hit_ceiling,
        output char_state, vel_x, vel_y, charge, face_left
    );
endinterface

// File: rtl/character_motion_controller.sv
// Per-tick player movement FSM: buttons and terrain contacts in,
// character state and signed X/Y velocities out.
module character_motion_controller #(
    parameter int SIGNED_PHY_WIDTH = 17,
    parameter int MAX_VEL_Y        = 10,
    parameter int MAX_VEL_X        = 4,
    parameter int GRAVITY          = 1,
    parameter int LAND_TICKS       = 2,
    parameter int CHARGE_WIDTH     = $clog2(MAX_VEL_Y + 1)
) (
    input logic                          sys_clk,
    input logic                          sys_rst,
    character_motion_controller_if.slave bus
);
    localparam int W  = SIGNED_PHY_WIDTH;
    localparam int LW = $clog2(LAND_TICKS + 1);

    localparam logic signed [W-1:0]     ZERO = '0;
    localparam logic signed [W-1:0]     VX   = W'(MAX_VEL_X);
    localparam logic signed [W-1:0]     VY   = W'(MAX_VEL_Y);
    localparam logic signed [W-1:0]     GR   = W'(GRAVITY);
    localparam logic [CHARGE_WIDTH-1:0] CMAX = CHARGE_WIDTH'(MAX_VEL_Y);
    localparam logic [LW-1:0]           LEND = LW'(LAND_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LEFT      = 3'd1,
        S_RIGHT     = 3'd2,
        S_CHARGE    = 3'd3,
        S_JUMP      = 3'd4,
        S_COLLISION = 3'd5,
        S_FALL      = 3'd6,
        S_HOLD      = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    state_e                  saved_q, saved_d;
    logic signed [W-1:0]     vel_x_q, vel_x_d;
    logic signed [W-1:0]     vel_y_q, vel_y_d;
    logic [CHARGE_WIDTH-1:0] charge_q, charge_d;
    logic                    face_q, face_d;
    logic [LW-1:0]           land_q, land_d;

    logic signed [W-1:0] vy_dec;
    logic signed [W-1:0] vy_air;
    logic                one_left;
    logic                one_right;
    logic                landing;

    // Airborne vertical update: ceiling stops upward motion, else gravity
    // pulls down with the fall speed clamped at -MAX_VEL_Y.
    always_comb begin
        one_left  = bus.btn_left & ~bus.btn_right;
        one_right = bus.btn_right & ~bus.btn_left;
        vy_dec    = vel_y_q - GR;
        landing   = bus.on_ground && (vel_y_q <= ZERO);
        if (bus.hit_ceiling && (vel_y_q > ZERO)) begin
            vy_air = ZERO;
        end else if (vy_dec < -VY) begin
            vy_air = -VY;
        end else begin
            vy_air = vy_dec;
        end
    end

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        vel_x_d  = vel_x_q;
        vel_y_d  = vel_y_q;
        charge_d = charge_q;
        face_d   = face_q;
        land_d   = land_q;
        if (bus.freeze) begin
            if (state_q != S_HOLD) begin
                saved_d = state_q;
                state_d = S_HOLD;
            end
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    state_d = saved_q;
                end
                S_IDLE, S_LEFT, S_RIGHT: begin
                    vel_y_d = ZERO;
                    if (!bus.on_ground) begin
                        state_d = S_JUMP;
                    end else if (bus.btn_jump) begin
                        state_d  = S_CHARGE;
                        charge_d = CHARGE_WIDTH'(1);
                        vel_x_d  = ZERO;
                    end else if (one_left) begin
                        state_d = S_LEFT;
                        vel_x_d = -VX;
                        face_d  = 1'b1;
                    end else if (one_right) begin
                        state_d = S_RIGHT;
                        vel_x_d = VX;
                        face_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        vel_x_d = ZERO;
                    end
                end
                S_CHARGE: begin
                    if (!bus.on_ground) begin
                        state_d  = S_JUMP;
                        vel_y_d  = ZERO;
                        charge_d = '0;
                    end else if (bus.btn_jump) begin
                        if (charge_q < CMAX) begin
                            charge_d = charge_q + 1'b1;
                        end
                    end else begin
                        state_d  = S_JUMP;
                        vel_y_d  = W'(charge_q);
                        charge_d = '0;
                        if (one_left) begin
                            vel_x_d = -VX;
                            face_d  = 1'b1;
                        end else if (one_right) begin
                            vel_x_d = VX;
                            face_d  = 1'b0;
                        end else begin
                            vel_x_d = ZERO;
                        end
                    end
                end
                S_JUMP, S_COLLISION: begin
                    // Touching down wins over any wall contact this tick.
                    if (landing) begin
                        state_d = S_FALL;
                        vel_x_d = ZERO;
                        land_d  = '0;
                    end else begin
                        vel_y_d = vy_air;
                        if (state_q == S_COLLISION) begin
                            state_d = S_JUMP;
                        end else if (bus.hit_wall) begin
                            state_d = S_COLLISION;
                            vel_x_d = -vel_x_q;
                            face_d  = ~face_q;
                        end
                    end
                end
                S_FALL: begin
                    vel_y_d = ZERO;
                    if (!bus.on_ground) begin
                        state_d = S_JUMP;
                    end else if (land_q >= LEND) begin
                        state_d = S_IDLE;
                    end else begin
                        land_d = land_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            saved_q  <= S_IDLE;
            vel_x_q  <= '0;
            vel_y_q  <= '0;
            charge_q <= '0;
            face_q   <= 1'b0;
            land_q   <= '0;
        end else if (bus.character_clk) begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            vel_x_q  <= vel_x_d;
            vel_y_q  <= vel_y_d;
            charge_q <= charge_d;
            face_q   <= face_d;
            land_q   <= land_d;
        end
    end

    assign bus.char_state = state_q;
    assign bus.vel_x      = vel_x_q;
    assign bus.vel_y      = vel_y_q;
    assign bus.charge     = charge_q;
    assign bus.face_left  = face_q;
endmodule

// File: tb/tb_character_motion_controller.sv
// Scenario bench for the character motion controller; expected states
// are queued as each tick is driven and compared once it has been taken.
module tb_character_motion_controller;
    localparam int IDLE = 0, LEFT = 1, RIGHT = 2, CHARGE = 3;
    localparam int JUMP = 4, COLL = 5, FALL = 6, HOLD = 7;

    typedef struct packed {
        logic fr, l, r, j, g, w, c;
    } stim_t;

    typedef struct packed {
        logic [2:0]         st;
        logic signed [16:0] vx;
        logic signed [16:0] vy;
        logic [3:0]         ch;
        logic               fl;
    } obs_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    character_motion_controller_if #(
        .SIGNED_PHY_WIDTH(17),
        .CHARGE_WIDTH(4)
    ) ifc ();

    character_motion_controller dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(ifc)
    );

    always #5 sys_clk = ~sys_clk;

    obs_t  obs;
    obs_t  sb[$];
    stim_t cur_st[$];
    obs_t  cur_ex[$];
    obs_t  e;
    int    n_chk  = 0;
    int    n_fail = 0;

    assign obs = {ifc.char_state, ifc.vel_x, ifc.vel_y,
                  ifc.charge, ifc.face_left};

    function automatic stim_t mk(bit fr, bit l, bit r, bit j,
                                 bit g, bit w, bit c);
        stim_t s;
        s = '{fr, l, r, j, g, w, c};
        return s;
    endfunction

    function automatic obs_t ex(int st, int vx, int vy, int ch, int fl);
        obs_t o;
        o.st = 3'(st);
        o.vx = 17'(vx);
        o.vy = 17'(vy);
        o.ch = 4'(ch);
        o.fl = 1'(fl);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d vx=%0d vy=%0d ch=%0d fl=%0d",
                         o.st, o.vx, o.vy, o.ch, o.fl);
    endfunction

    task automatic drive(stim_t s);
        ifc.freeze      = s.fr;
        ifc.btn_left    = s.l;
        ifc.btn_right   = s.r;
        ifc.btn_jump    = s.j;
        ifc.on_ground   = s.g;
        ifc.hit_wall    = s.w;
        ifc.hit_ceiling = s.c;
    endtask

    // One physics tick, then a non-tick cycle carrying random junk inputs.
    task automatic tick(stim_t s);
        logic [6:0] junk;
        drive(s);
        ifc.character_clk = 1'b1;
        @(posedge sys_clk);
        #1;
        ifc.character_clk = 1'b0;
        junk = 7'($urandom);
        drive(junk);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        ifc.character_clk = 1'b0;
        drive(mk(0, 0, 0, 0, 1, 0, 0));
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic add(stim_t s, obs_t o);
        cur_st.push_back(s);
        cur_ex.push_back(o);
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back(ex(IDLE, 0, 0, 0, 0));
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset: got %s want %s", fmt(obs), fmt(e));
        end
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 3; i++)
            add(mk(0, 0, 0, 0, 1, 0, 0), ex(IDLE, 0, 0, 0, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_walk();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        add(mk(0, 1, 0, 0, 1, 0, 0), ex(LEFT, -4, 0, 0, 1));
        add(mk(0, 1, 1, 0, 1, 0, 0), ex(IDLE, 0, 0, 0, 1));
        add(mk(0, 0, 1, 0, 1, 0, 0), ex(RIGHT, 4, 0, 0, 0));
        add(mk(0, 0, 1, 0, 0, 0, 0), ex(JUMP, 4, 0, 0, 0));
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(JUMP, 4, -1, 0, 0));
        add(mk(0, 0, 0, 0, 1, 0, 0), ex(FALL, 0, -1, 0, 0));
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(JUMP, 0, 0, 0, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL walk[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_charge_jump();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 15; i++)
            add(mk(0, 0, 1, 1, 1, 0, 0),
                ex(CHARGE, 0, 0, (i + 1 > 10) ? 10 : i + 1, 0));
        add(mk(0, 0, 1, 0, 1, 0, 0), ex(JUMP, 4, 10, 0, 0));
        add(mk(0, 0, 0, 0, 1, 0, 0), ex(JUMP, 4, 9, 0, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL charge[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_free_fall();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(JUMP, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            add(mk(0, 0, 0, 0, 0, 0, 0),
                ex(JUMP, 0, (i + 1 > 10) ? -10 : -(i + 1), 0, 0));
        add(mk(0, 0, 0, 0, 1, 0, 0), ex(FALL, 0, -10, 0, 0));
        add(mk(0, 1, 0, 1, 1, 0, 0), ex(FALL, 0, 0, 0, 0));
        add(mk(0, 1, 0, 1, 1, 0, 0), ex(IDLE, 0, 0, 0, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fall[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_wall();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 5; i++)
            add(mk(0, 0, 0, 1, 1, 0, 0), ex(CHARGE, 0, 0, i + 1, 0));
        add(mk(0, 0, 1, 0, 1, 0, 0), ex(JUMP, 4, 5, 0, 0));
        add(mk(0, 0, 0, 0, 0, 1, 0), ex(COLL, -4, 4, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(JUMP, -4, 3, 0, 1));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL wall[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_ceiling_wall();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 6; i++)
            add(mk(0, 0, 0, 1, 1, 0, 0), ex(CHARGE, 0, 0, i + 1, 0));
        add(mk(0, 0, 1, 0, 1, 0, 0), ex(JUMP, 4, 6, 0, 0));
        add(mk(0, 0, 0, 0, 0, 1, 1), ex(COLL, -4, 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(JUMP, -4, -1, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1), ex(JUMP, -4, -2, 0, 1));
        add(mk(0, 0, 0, 0, 1, 1, 0), ex(FALL, 0, -2, 0, 1));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ceil[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 4; i++)
            add(mk(0, 0, 0, 1, 1, 0, 0), ex(CHARGE, 0, 0, i + 1, 0));
        for (int i = 0; i < 5; i++)
            add(mk(1, 0, 0, 0, 0, 1, 1), ex(HOLD, 0, 0, 4, 0));
        add(mk(0, 0, 0, 0, 0, 0, 0), ex(CHARGE, 0, 0, 4, 0));
        add(mk(0, 0, 0, 1, 1, 0, 0), ex(CHARGE, 0, 0, 5, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        cur_st.delete();
        cur_ex.delete();
        for (int i = 0; i < 3; i++)
            add(mk(0, 0, 0, 1, 1, 0, 0), ex(CHARGE, 0, 0, i + 1, 0));
        add(mk(0, 1, 0, 0, 1, 0, 0), ex(JUMP, -4, 3, 0, 1));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL prejump[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
        // Reset together with a tick and freeze must still win.
        sb.push_back(ex(IDLE, 0, 0, 0, 0));
        drive(mk(1, 0, 0, 1, 0, 1, 1));
        ifc.character_clk = 1'b1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        ifc.character_clk = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL rst_mid_jump: got %s want %s", fmt(obs), fmt(e));
        end
        cur_st.delete();
        cur_ex.delete();
        add(mk(1, 0, 0, 0, 1, 0, 0), ex(HOLD, 0, 0, 0, 0));
        add(mk(0, 0, 0, 0, 1, 0, 0), ex(IDLE, 0, 0, 0, 0));
        for (int i = 0; i < cur_st.size(); i++) begin
            sb.push_back(cur_ex[i]);
            tick(cur_st[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL postrst[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            end
        end
    endtask

    initial begin
        ifc.character_clk = 1'b0;
        drive(mk(0, 0, 0, 0, 1, 0, 0));
        repeat (2) @(posedge sys_clk);
        #1;
        test_reset();
        test_walk();
        test_charge_jump();
        test_free_fall();
        test_wall();
        test_ceiling_wall();
        test_freeze();
        test_reset_mid_jump();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
